// File: rtl/breakpoint_688_pkg.sv
// Shared definitions for the breakpoint_688 address-breakpoint unit:
// state encoding and default widths.
package breakpoint_688_pkg;

    localparam int unsigned BP_ADDR_WIDTH = 16;
    localparam int unsigned BP_PC_WIDTH   = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ARMED     = 2'd1,
        ST_TRIGGERED = 2'd2
    } bp_state_e;

endpackage

// File: rtl/breakpoint_688_comparator.sv
// 74x688-style 8-bit equality comparator with active-low cascade input.
// neq is low only when p == q and the upstream stage also reported equal.
module comparator_688 (
    input  logic [7:0] p,
    input  logic [7:0] q,
    input  logic       ng,
    output logic       neq
);

    assign neq = ng | (p != q);

endmodule

// File: rtl/breakpoint_688.sv
// Registered address-breakpoint unit: cascaded byte comparators feed a
// three-state arm/trigger FSM. Optional pass counter: BREAKPOINT_PASSCOUNT_EN.
module breakpoint_688
    import breakpoint_688_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = BP_ADDR_WIDTH,
    parameter int unsigned PC_WIDTH   = BP_PC_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] ab,
    input  logic                  nmem,
    input  logic [ADDR_WIDTH-1:0] db,
    input  logic                  nwr_bp,
    input  logic                  nwr_pc,
    input  logic                  narm,
    input  logic                  nack,
    output logic                  nbrk,
    output logic                  armed,
    output logic [PC_WIDTH-1:0]   pc_left
);

    localparam int unsigned NBYTES = ADDR_WIDTH / 8;

    bp_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] bp_q, bp_d;
    logic                  nmem_q;
    logic [NBYTES:0]       ng_chain;
    logic                  match_w;
    logic                  event_w;
    logic                  hit_w;
    logic                  pc_zero_w;

    // Byte comparators chained LSB to MSB; the top stage's neq is the verdict.
    assign ng_chain[0] = 1'b0;

    for (genvar i = 0; i < NBYTES; i++) begin : g_cmp
        comparator_688 u_cmp (
            .p   (ab[8*i +: 8]),
            .q   (bp_q[8*i +: 8]),
            .ng  (ng_chain[i]),
            .neq (ng_chain[i+1])
        );
    end

    assign match_w = ~ng_chain[NBYTES];
    assign event_w = ~nmem & nmem_q;
    assign hit_w   = event_w & match_w;

    assign bp_d = nwr_bp ? bp_q : db;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bp_q   <= '0;
            nmem_q <= 1'b1;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            bp_q   <= bp_d;
            nmem_q <= nmem;
        end
    end

`ifdef BREAKPOINT_PASSCOUNT_EN
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                count_w;

    assign pc_zero_w = (pc_q == '0);
    assign count_w   = (state_q == ST_ARMED) & nack & hit_w & ~pc_zero_w;

    // A load in the same cycle as a counted event wins: new value applies next.
    always_comb begin
        pc_d = pc_q;
        if (!nwr_pc) begin
            pc_d = db[PC_WIDTH-1:0];
        end else if (count_w) begin
            pc_d = pc_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_left = pc_q;
`else
    logic unused_nwr_pc;

    assign unused_nwr_pc = nwr_pc;
    assign pc_zero_w     = 1'b1;
    assign pc_left       = '0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch forms.
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (nack && !narm) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (!nack) begin
                    state_d = ST_IDLE;
                end else if (hit_w && pc_zero_w) begin
                    state_d = ST_TRIGGERED;
                end
            end
            ST_TRIGGERED: begin
                if (!nack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        nbrk  = 1'b1;
        armed = 1'b0;
        unique case (state_q)
            ST_ARMED:     armed = 1'b1;
            ST_TRIGGERED: nbrk  = 1'b0;
            default: begin
                nbrk  = 1'b1;
                armed = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_breakpoint_688.sv
// Self-checking bench for breakpoint_688: behavioural model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_breakpoint_688;

`ifdef BREAKPOINT_PASSCOUNT_EN
    localparam bit PC_EN = 1'b1;
`else
    localparam bit PC_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] ab;
    logic        nmem;
    logic [15:0] db;
    logic        nwr_bp;
    logic        nwr_pc;
    logic        narm;
    logic        nack;
    logic        nbrk;
    logic        armed;
    logic [7:0]  pc_left;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: plain flags and an integer counter.
    bit          m_armed = 0;
    bit          m_trig  = 0;
    logic [15:0] m_bp    = '0;
    int          m_pc    = 0;
    bit          m_prev  = 1;

    breakpoint_688 dut (
        .clk     (clk),
        .reset   (reset),
        .ab      (ab),
        .nmem    (nmem),
        .db      (db),
        .nwr_bp  (nwr_bp),
        .nwr_pc  (nwr_pc),
        .narm    (narm),
        .nack    (nack),
        .nbrk    (nbrk),
        .armed   (armed),
        .pc_left (pc_left)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update at each rising edge, then compare once outputs settle.
    always @(posedge clk) begin
        bit ev;
        bit hit;
        if (reset) begin
            m_armed = 0; m_trig = 0; m_bp = '0; m_pc = 0; m_prev = 1;
        end else begin
            ev  = !nmem && m_prev;
            hit = ev && (ab == m_bp);
            if (!nack) begin
                m_armed = 0;
                m_trig  = 0;
            end else if (m_armed && hit) begin
                if (m_pc == 0) begin
                    m_armed = 0;
                    m_trig  = 1;
                end else begin
                    m_pc = m_pc - 1;
                end
            end else if (!m_armed && !m_trig && !narm) begin
                m_armed = 1;
            end
            if (!nwr_bp) m_bp = db;
            if (PC_EN && !nwr_pc) m_pc = int'(db[7:0]);
            m_prev = nmem;
        end
        #1;
        check("model_nbrk", 32'(nbrk), 32'(!m_trig));
        check("model_armed", 32'(armed), 32'(m_armed));
        check("model_pc_left", 32'(pc_left), 32'(m_pc));
    end

    task automatic idle_inputs();
        nmem = 1'b1; nwr_bp = 1'b1; nwr_pc = 1'b1; narm = 1'b1; nack = 1'b1;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wr_bp(input logic [15:0] v);
        db = v; nwr_bp = 1'b0; step(); nwr_bp = 1'b1;
    endtask

    task automatic wr_pc(input logic [15:0] v);
        db = v; nwr_pc = 1'b0; step(); nwr_pc = 1'b1;
    endtask

    task automatic arm();
        narm = 1'b0; step(); narm = 1'b1;
    endtask

    task automatic ack();
        nack = 1'b0; step(); nack = 1'b1;
    endtask

    // One idle clock, then n clocks with nmem low; returns before nmem rises.
    task automatic mem(input logic [15:0] a, input int n);
        ab = a; nmem = 1'b1; step();
        nmem = 1'b0;
        repeat (n) step();
        nmem = 1'b1;
    endtask

    function automatic logic [15:0] pick_addr();
        logic [15:0] c [4];
        c[0] = 16'h1234; c[1] = 16'h00FF; c[2] = 16'h2000; c[3] = 16'h0002;
        if ($urandom_range(0, 4) == 0) return 16'($urandom);
        return c[$urandom_range(0, 3)];
    endfunction

    initial begin
        reset = 1'b1; ab = '0; db = '0;
        idle_inputs();
        step(); step();
        check("reset_nbrk", 32'(nbrk), 32'd1);
        check("reset_armed", 32'(armed), 32'd0);
        check("reset_pc_left", 32'(pc_left), 32'd0);
        reset = 1'b0;
        step();

        // Basic break and near-miss address.
        wr_bp(16'h1234);
        arm();
        check("arm_rise", 32'(armed), 32'd1);
        mem(16'h1234, 1);
        check("basic_break", 32'(nbrk), 32'd0);
        ack();
        check("ack_release", 32'(nbrk), 32'd1);
        arm();
        mem(16'h1235, 1);
        check("miss_no_break", 32'(nbrk), 32'd1);
        check("miss_still_armed", 32'(armed), 32'd1);

        // Pass count of 2: the third matching cycle breaks.
        ack();
        wr_bp(16'h00FF);
        wr_pc(16'h0002);
        arm();
        mem(16'h00FF, 1);
        if (PC_EN) begin
            check("pc_first", 32'(pc_left), 32'd1);
            check("pc_first_nobrk", 32'(nbrk), 32'd1);
            mem(16'h00FF, 1);
            check("pc_second", 32'(pc_left), 32'd0);
            check("pc_second_nobrk", 32'(nbrk), 32'd1);
            mem(16'h00FF, 1);
        end
        check("pc_break", 32'(nbrk), 32'd0);

        // A long memory cycle is a single event.
        ack();
        wr_pc(16'h0001);
        arm();
        mem(16'h00FF, 5);
        if (PC_EN) begin
            check("long_pc", 32'(pc_left), 32'd0);
            check("long_nobrk", 32'(nbrk), 32'd1);
        end else begin
            check("long_brk", 32'(nbrk), 32'd0);
        end

        // nack together with a matching event.
        ack();
        wr_pc(16'h0000);
        arm();
        ab = 16'h00FF; nmem = 1'b1; step();
        nack = 1'b0; nmem = 1'b0; step();
        nack = 1'b1; nmem = 1'b1;
        check("simul_nbrk", 32'(nbrk), 32'd1);
        check("simul_armed", 32'(armed), 32'd0);

        // Breakpoint write in the same cycle as an event uses the old address.
        wr_bp(16'h1000);
        arm();
        ab = 16'h2000; step();
        db = 16'h2000; nwr_bp = 1'b0; nmem = 1'b0; step();
        nwr_bp = 1'b1; nmem = 1'b1;
        check("collide_nobrk", 32'(nbrk), 32'd1);
        mem(16'h2000, 1);
        check("collide_next_brk", 32'(nbrk), 32'd0);

        // Asynchronous reset while triggered.
        #2 reset = 1'b1;
        #1;
        check("async_rst_nbrk", 32'(nbrk), 32'd1);
        check("async_rst_armed", 32'(armed), 32'd0);
        check("async_rst_pc", 32'(pc_left), 32'd0);
        step();
        reset = 1'b0;
        step();

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            ab     = pick_addr();
            db     = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 3)) : pick_addr();
            nmem   = 1'($urandom_range(0, 1));
            nwr_bp = ($urandom_range(0, 15) != 0);
            nwr_pc = ($urandom_range(0, 11) != 0);
            narm   = ($urandom_range(0, 3) != 0);
            nack   = ($urandom_range(0, 9) != 0);
            reset  = ($urandom_range(0, 299) == 0);
            step();
        end
        reset = 1'b0;
        idle_inputs();
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
